// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage
// Description : Writeback stage. In-order queue of MEM results that commits
//               to the register file and the flag register, waits on load data,
//               and halts the core.
// Revision    : 1.0 - initial release
// ============================================================================

module wb_stage #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     v_in,
    output logic                     rdy_out,
    input  logic [2:0]               rd,
    input  logic [15:0]              res,
    input  logic                     is_load,
    input  logic [15:0]              fl_res,
    input  logic                     fl_wr,
    input  logic                     halt_in,
    input  logic [15:0]              mem_data,
    input  logic                     mem_ack,
    output logic [2:0]               ws,
    output logic                     we,
    output logic [15:0]              in,
    output logic [15:0]              fl_in,
    output logic                     fl_en,
    output logic                     he,
    output logic [$clog2(DEPTH):0]   occ
);

    localparam int              C_AW   = $clog2(DEPTH);
    localparam logic [C_AW:0]   C_FULL = (C_AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        HALTED   = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0]  rd;
        logic [15:0] res;
        logic        is_load;
        logic [15:0] fl_res;
        logic        fl_wr;
        logic        halt;
    } entry_t;

    entry_t             r_q [DEPTH];
    state_t             r_state;
    logic [C_AW-1:0]    r_wr_ptr;
    logic [C_AW-1:0]    r_rd_ptr;
    logic [C_AW:0]      r_occ;
    logic               r_we;
    logic               r_fl_en;
    logic               r_he;
    logic [2:0]         r_ws;
    logic [15:0]        r_in;
    logic [15:0]        r_fl_in;

    entry_t             w_head;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;

    assign w_head  = r_q[r_rd_ptr];
    assign w_empty = (r_occ == '0);
    assign rdy_out = (r_occ < C_FULL) && (r_state != HALTED);
    assign w_push  = v_in && rdy_out;

    // A halt at the head retires even if it is also flagged as a load.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            IDLE:     w_pop = !w_empty && (w_head.halt || !w_head.is_load);
            WAIT_MEM: w_pop = mem_ack;
            default:  w_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q[r_wr_ptr] <= '{rd: rd, res: res, is_load: is_load,
                               fl_res: fl_res, fl_wr: fl_wr, halt: halt_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_we     <= 1'b0;
            r_fl_en  <= 1'b0;
            r_he     <= 1'b0;
            r_ws     <= '0;
            r_in     <= '0;
            r_fl_in  <= '0;
        end else begin
            r_we    <= 1'b0;
            r_fl_en <= 1'b0;
            if (w_push) r_wr_ptr <= r_wr_ptr + C_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + C_AW'(1);
            r_occ <= r_occ + (C_AW+1)'(w_push) - (C_AW+1)'(w_pop);

            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        if (w_head.halt) begin
                            r_he    <= 1'b1;
                            r_state <= HALTED;
                        end else if (w_head.is_load) begin
                            r_state <= WAIT_MEM;
                        end else begin
                            r_we    <= 1'b1;
                            r_ws    <= w_head.rd;
                            r_in    <= w_head.res;
                            r_fl_en <= w_head.fl_wr;
                            r_fl_in <= w_head.fl_res;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (mem_ack) begin
                        r_we    <= 1'b1;
                        r_ws    <= w_head.rd;
                        r_in    <= mem_data;
                        r_fl_en <= w_head.fl_wr;
                        r_fl_in <= w_head.fl_res;
                        r_state <= IDLE;
                    end
                end
                HALTED: begin
                    r_state <= HALTED;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign we    = r_we;
    assign fl_en = r_fl_en;
    assign he    = r_he;
    assign ws    = r_ws;
    assign in    = r_in;
    assign fl_in = r_fl_in;
    assign occ   = r_occ;

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage
// Description : Directed self-checking bench for wb_stage (DEPTH = 2).
// Revision    : 1.0 - initial release
// ============================================================================

module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v_in;
    logic        rdy_out;
    logic [2:0]  rd;
    logic [15:0] res;
    logic        is_load;
    logic [15:0] fl_res;
    logic        fl_wr;
    logic        halt_in;
    logic [15:0] mem_data;
    logic        mem_ack;
    logic [2:0]  ws;
    logic        we;
    logic [15:0] in;
    logic [15:0] fl_in;
    logic        fl_en;
    logic        he;
    logic [1:0]  occ;

    int total = 0;
    int bad   = 0;

    wb_stage #(.DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .v_in(v_in), .rdy_out(rdy_out),
        .rd(rd), .res(res), .is_load(is_load), .fl_res(fl_res),
        .fl_wr(fl_wr), .halt_in(halt_in), .mem_data(mem_data),
        .mem_ack(mem_ack), .ws(ws), .we(we), .in(in), .fl_in(fl_in),
        .fl_en(fl_en), .he(he), .occ(occ)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        total++; if (occ !== 2'd0) begin bad++; $display("FAIL rst_occ: got %0d want 0", occ); end
        total++; if (we !== 1'b0) begin bad++; $display("FAIL rst_we: got %b want 0", we); end
        total++; if (fl_en !== 1'b0) begin bad++; $display("FAIL rst_fl_en: got %b want 0", fl_en); end
        total++; if (he !== 1'b0) begin bad++; $display("FAIL rst_he: got %b want 0", he); end
        total++; if ({ws, in, fl_in} !== 35'd0) begin bad++; $display("FAIL rst_data: got ws=%h in=%h fl_in=%h want 0", ws, in, fl_in); end
        rst_n = 1'b1;
        step();
        total++; if (rdy_out !== 1'b1) begin bad++; $display("FAIL rst_rdy: got %b want 1", rdy_out); end
    endtask

    task automatic test_single();
        v_in = 1'b1; rd = 3'd3; res = 16'h1234; is_load = 1'b0; fl_wr = 1'b0; fl_res = 16'h0F0F;
        step();
        v_in = 1'b0;
        total++; if (we !== 1'b0) begin bad++; $display("FAIL single_early_we: got %b want 0", we); end
        total++; if (occ !== 2'd1) begin bad++; $display("FAIL single_occ: got %0d want 1", occ); end
        step();
        total++; if (we !== 1'b1 || ws !== 3'd3 || in !== 16'h1234) begin bad++; $display("FAIL single_commit: got we=%b ws=%0d in=%h want 1/3/1234", we, ws, in); end
        total++; if (fl_en !== 1'b0) begin bad++; $display("FAIL single_fl_en: got %b want 0", fl_en); end
        step();
        total++; if (we !== 1'b0 || ws !== 3'd3 || in !== 16'h1234) begin bad++; $display("FAIL single_after: got we=%b ws=%0d in=%h want 0/3/1234", we, ws, in); end
    endtask

    task automatic test_load();
        v_in = 1'b1; rd = 3'd5; res = 16'h1111; is_load = 1'b1;
        step();
        v_in = 1'b0; is_load = 1'b0; mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (we !== 1'b0) begin bad++; $display("FAIL load_wait_we[%0d]: got %b want 0", i, we); end
        end
        mem_ack = 1'b1; mem_data = 16'hBEEF;
        step();
        total++; if (we !== 1'b1 || ws !== 3'd5 || in !== 16'hBEEF) begin bad++; $display("FAIL load_commit: got we=%b ws=%0d in=%h want 1/5/beef", we, ws, in); end
        mem_ack = 1'b0;
        step();
        total++; if (we !== 1'b0 || occ !== 2'd0) begin bad++; $display("FAIL load_after: got we=%b occ=%0d want 0/0", we, occ); end
    endtask

    task automatic test_ack_ignored();
        mem_ack = 1'b1; mem_data = 16'hDEAD;
        step();
        total++; if (we !== 1'b0) begin bad++; $display("FAIL ack_idle_empty: got we=%b want 0", we); end
        v_in = 1'b1; rd = 3'd6; res = 16'h0000; is_load = 1'b1;
        step();
        v_in = 1'b0; is_load = 1'b0;
        step();
        total++; if (we !== 1'b0) begin bad++; $display("FAIL ack_idle_head: got we=%b want 0", we); end
        step();
        total++; if (we !== 1'b1 || ws !== 3'd6 || in !== 16'hDEAD) begin bad++; $display("FAIL ack_wait_commit: got we=%b ws=%0d in=%h want 1/6/dead", we, ws, in); end
        mem_ack = 1'b0;
        step();
        total++; if (we !== 1'b0) begin bad++; $display("FAIL ack_after: got we=%b want 0", we); end
    endtask

    task automatic test_full();
        v_in = 1'b1; rd = 3'd1; res = 16'h0011; is_load = 1'b1;
        step();
        rd = 3'd2; res = 16'h0022; is_load = 1'b0;
        step();
        rd = 3'd4; res = 16'h0044;
        #1;
        total++; if (occ !== 2'd2 || rdy_out !== 1'b0) begin bad++; $display("FAIL full_state: got occ=%0d rdy=%b want 2/0", occ, rdy_out); end
        step();
        total++; if (occ !== 2'd2 || we !== 1'b0) begin bad++; $display("FAIL full_hold: got occ=%0d we=%b want 2/0", occ, we); end
        mem_ack = 1'b1; mem_data = 16'hAAAA;
        step();
        total++; if (we !== 1'b1 || ws !== 3'd1 || in !== 16'hAAAA || occ !== 2'd1) begin bad++; $display("FAIL full_first: got we=%b ws=%0d in=%h occ=%0d want 1/1/aaaa/1", we, ws, in, occ); end
        v_in = 1'b0; mem_ack = 1'b0;
        step();
        total++; if (we !== 1'b1 || ws !== 3'd2 || in !== 16'h0022 || occ !== 2'd0) begin bad++; $display("FAIL full_second: got we=%b ws=%0d in=%h occ=%0d want 1/2/0022/0", we, ws, in, occ); end
        step();
        total++; if (we !== 1'b0 || occ !== 2'd0) begin bad++; $display("FAIL full_drained: got we=%b occ=%0d want 0/0", we, occ); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_res;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                v_in = 1'b1; rd = 3'(i); res = 16'h0100 + 16'(i); is_load = 1'b0;
            end else begin
                v_in = 1'b0;
            end
            step();
            if (i >= 1) begin
                exp_res = 16'h0100 + 16'(i - 1);
                total++; if (we !== 1'b1 || ws !== 3'(i - 1) || in !== exp_res) begin bad++; $display("FAIL b2b[%0d]: got we=%b ws=%0d in=%h want 1/%0d/%h", i - 1, we, ws, in, i - 1, exp_res); end
            end
        end
        step();
        total++; if (we !== 1'b0 || occ !== 2'd0) begin bad++; $display("FAIL b2b_end: got we=%b occ=%0d want 0/0", we, occ); end
    endtask

    task automatic test_halt();
        v_in = 1'b1; rd = 3'd6; res = 16'h0066; fl_wr = 1'b1; fl_res = 16'h0005;
        step();
        rd = 3'd0; res = 16'h0000; fl_wr = 1'b0; fl_res = 16'h0009; halt_in = 1'b1; is_load = 1'b1;
        step();
        total++; if (we !== 1'b1 || ws !== 3'd6 || in !== 16'h0066) begin bad++; $display("FAIL halt_pre_commit: got we=%b ws=%0d in=%h want 1/6/0066", we, ws, in); end
        total++; if (fl_en !== 1'b1 || fl_in !== 16'h0005 || he !== 1'b0) begin bad++; $display("FAIL halt_pre_flag: got fl_en=%b fl_in=%h he=%b want 1/0005/0", fl_en, fl_in, he); end
        halt_in = 1'b0; is_load = 1'b0; rd = 3'd7; res = 16'h0077;
        step();
        total++; if (we !== 1'b0 || fl_en !== 1'b0 || he !== 1'b1) begin bad++; $display("FAIL halt_enter: got we=%b fl_en=%b he=%b want 0/0/1", we, fl_en, he); end
        total++; if (rdy_out !== 1'b0 || occ !== 2'd1) begin bad++; $display("FAIL halt_rdy: got rdy=%b occ=%0d want 0/1", rdy_out, occ); end
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (we !== 1'b0 || he !== 1'b1 || rdy_out !== 1'b0 || occ !== 2'd1) begin bad++; $display("FAIL halt_frozen[%0d]: got we=%b he=%b rdy=%b occ=%0d want 0/1/0/1", i, we, he, rdy_out, occ); end
            total++; if (ws !== 3'd6 || fl_in !== 16'h0005) begin bad++; $display("FAIL halt_hold[%0d]: got ws=%0d fl_in=%h want 6/0005", i, ws, fl_in); end
        end
        v_in = 1'b0;
    endtask

    task automatic test_reset_wait();
        rst_n = 1'b0;
        #1;
        total++; if (he !== 1'b0 || occ !== 2'd0 || we !== 1'b0) begin bad++; $display("FAIL rst_from_halt: got he=%b occ=%0d we=%b want 0/0/0", he, occ, we); end
        #1 rst_n = 1'b1;
        v_in = 1'b1; rd = 3'd2; res = 16'h0202; is_load = 1'b1;
        step();
        rd = 3'd3; res = 16'h0303; is_load = 1'b0;
        step();
        v_in = 1'b0;
        total++; if (occ !== 2'd2 || we !== 1'b0) begin bad++; $display("FAIL rstw_pre: got occ=%0d we=%b want 2/0", occ, we); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (occ !== 2'd0 || we !== 1'b0 || he !== 1'b0) begin bad++; $display("FAIL rstw_async: got occ=%0d we=%b he=%b want 0/0/0", occ, we, he); end
        #3 rst_n = 1'b1;
        mem_ack = 1'b1; mem_data = 16'hCCCC;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (we !== 1'b0 || occ !== 2'd0) begin bad++; $display("FAIL rstw_ack[%0d]: got we=%b occ=%0d want 0/0", i, we, occ); end
        end
        mem_ack = 1'b0;
        total++; if (rdy_out !== 1'b1) begin bad++; $display("FAIL rstw_rdy: got %b want 1", rdy_out); end
    endtask

    initial begin
        rst_n = 1'b0; v_in = 1'b0; rd = '0; res = '0; is_load = 1'b0;
        fl_res = '0; fl_wr = 1'b0; halt_in = 1'b0; mem_data = '0; mem_ack = 1'b0;
        #12;
        test_reset();
        test_single();
        test_load();
        test_ack_ignored();
        test_full();
        test_back_to_back();
        test_halt();
        test_reset_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter DEPTH, default 2, writeback queue entries (power of two, >=2).
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 V_IN  input  1  upstream (MEM stage) result valid.
REQ-005 RDY_OUT  output  1  stage can accept an entry this cycle.
REQ-006 RD  input  3  destination register select.
REQ-007 RES  input  16  ALU/address result.
REQ-008 IS_LOAD  input  1  entry's data comes from memory, not RES.
REQ-009 FL_RES  input  16  flag word produced by entry.
REQ-010 FL_WR  input  1  entry updates the flag register.
REQ-011 HALT_IN  input  1  entry is a halt instruction.
REQ-012 MEM_DATA  input  16  load data from data memory.
REQ-013 MEM_ACK  input  1  MEM_DATA valid this cycle.
REQ-014 WS  output  3  register-file write select.
REQ-015 WE  output  1  register-file write enable.
REQ-016 IN  output  16  register-file write data.
REQ-017 FL_IN  output  16  flag write data.
REQ-018 FL_EN  output  1  flag write enable.
REQ-019 HE  output  1  halt enable to register file/core.
REQ-020 OCC  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-021 Entry {RD,RES,IS_LOAD,FL_RES,FL_WR,HALT_IN} SHALL be pushed at an edge where V_IN && RDY_OUT.
REQ-022 RDY_OUT SHALL equal (OCC < DEPTH) && state != HALTED, combinationally; no push when full even if a pop occurs the same edge.
REQ-023 FSM states IDLE, WAIT_MEM, HALTED.
REQ-024 IDLE, head non-load non-halt: at next edge pop head; WE<=1, WS<=RD, IN<=RES, FL_EN<=FL_WR, FL_IN<=FL_RES.
REQ-025 IDLE, head IS_LOAD: at next edge move to WAIT_MEM, no pop, no commit.
REQ-026 WAIT_MEM: edge with MEM_ACK=1 SHALL pop head, commit as REQ-024 but IN<=MEM_DATA, return to IDLE; MEM_ACK=0 holds state.
REQ-027 MEM_ACK outside WAIT_MEM SHALL be ignored.
REQ-028 IDLE, head HALT_IN: at next edge pop, WE<=0, FL_EN<=0, HE<=1, enter HALTED; HALT_IN overrides IS_LOAD.
REQ-029 HALTED SHALL persist until reset; no pushes, no commits, HE stays 1, remaining entries frozen.
REQ-030 WE and FL_EN SHALL be registered single-cycle pulses, 0 in any cycle without a commit; WS/IN/FL_IN hold last committed values.
REQ-031 Latency: entry pushed into empty queue at edge N, non-load, SHALL commit (WE=1) after edge N+1.
REQ-032 Throughput: back-to-back non-load entries SHALL commit one per cycle.
REQ-033 Commits SHALL occur strictly in push order; RD=0 is written like any register.
REQ-034 Simultaneous push and pop SHALL leave OCC unchanged; queue pointers wrap modulo DEPTH.

Reset
REQ-035 RST_N=0 SHALL immediately clear: state IDLE, queue empty, OCC=0, WE=0, FL_EN=0, HE=0, WS=0, IN=0, FL_IN=0.
REQ-036 Reset during WAIT_MEM SHALL abandon the pending load; a later MEM_ACK SHALL not commit.
REQ-037 RDY_OUT SHALL be 1 from first cycle after RST_N deasserts.

Verification
REQ-038 Push RD=3,RES=0x1234 into empty queue -> one cycle later WE=1,WS=3,IN=0x1234, next cycle WE=0.
REQ-039 Push load RD=5, MEM_ACK held 0 for 3 cycles then 1 with MEM_DATA=0xBEEF -> single WE pulse WS=5,IN=0xBEEF on ack edge; none before.
REQ-040 With DEPTH=2, hold head load unacked, push 2 entries -> OCC=2, RDY_OUT=0; third V_IN not accepted; after ack entries commit in order.
REQ-041 Push FL_WR=1,FL_RES=0x0005 then HALT_IN=1 -> FL_EN pulse with FL_IN=0x0005, then HE=1, RDY_OUT=0 permanently, no further WE.
REQ-042 Assert RST_N=0 asynchronously in WAIT_MEM with OCC=2 -> OCC=0, WE=0, HE=0 before next edge; post-reset MEM_ACK produces no write.
REQ-043 Stream 8 non-load entries RD=0..7 with V_IN held 1 -> 8 consecutive WE cycles, WS=0..7 in order.
